// File: rtl/heq_phase_sequencer.sv
// heq_phase_sequencer: runs CLEAR, HIST, CDF, DIV and OUT in order and drives the one-hot memory grant.
// Define PHASE_WATCHDOG_EN to build the per-phase watchdog that can park the sequencer in ERR.
module heq_phase_sequencer #(
   parameter int NUM_BINS       = 256,
   parameter int ADDR_W         = 8,
   parameter int DATA_W         = 16,
   parameter int TIMEOUT_CYCLES = 65536
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic              histogram_done,
   input  logic              cdf_done,
   input  logic              divider_done,
   input  logic              output_done,
   output logic              start_histogram,
   output logic              start_cdf,
   output logic              start_divider,
   output logic              start_output,
   output logic              clear_en,
   output logic              histogram_en,
   output logic              cdf_en,
   output logic              divider_en,
   output logic              output_en,
   output logic              clear_WE,
   output logic [ADDR_W-1:0] clear_waddr,
   output logic [DATA_W-1:0] clear_wdata,
   output logic              busy,
   output logic              frame_done,
   output logic              error,
   output logic [2:0]        phase
);
   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_HIST, S_CDF, S_DIV, S_OUT, S_DONE, S_ERR} state_t;
   state_t            state, nxt;
   logic              valid_done, timeout;
   logic [4:0]        grant_d;
   logic [3:0]        start_d;
   logic [ADDR_W-1:0] addr_d;
   logic              busy_d, frame_done_d, error_d;
   // A done coinciding with the phase's own start pulse is too early to be trusted.
   assign valid_done = (state == S_HIST && histogram_done && !start_histogram) ||
                       (state == S_CDF  && cdf_done       && !start_cdf)       ||
                       (state == S_DIV  && divider_done   && !start_divider)   ||
                       (state == S_OUT  && output_done    && !start_output);
`ifdef PHASE_WATCHDOG_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt;
   always_ff @(posedge clock or posedge reset)
      if (reset) cnt <= '0;
      else cnt <= (nxt != state) ? '0 : cnt + 1'b1;
   assign timeout = state inside {S_HIST, S_CDF, S_DIV, S_OUT} && cnt == CNT_W'(TIMEOUT_CYCLES - 1);
`else
   assign timeout = 1'b0;
`endif
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state <= S_IDLE;
         {output_en, divider_en, cdf_en, histogram_en, clear_en} <= '0;
         {start_output, start_divider, start_cdf, start_histogram} <= '0;
         clear_WE <= 1'b0;
         clear_waddr <= '0;
         busy <= 1'b0;
         frame_done <= 1'b0;
         error <= 1'b0;
      end else begin
         state <= nxt;
         {output_en, divider_en, cdf_en, histogram_en, clear_en} <= grant_d;
         {start_output, start_divider, start_cdf, start_histogram} <= start_d;
         clear_WE <= grant_d[0];
         clear_waddr <= addr_d;
         busy <= busy_d;
         frame_done <= frame_done_d;
         error <= error_d;
      end
   always_comb begin
      nxt = state;
      if (abort) nxt = S_IDLE;
      else case (state)
         S_IDLE, S_DONE: nxt = start ? S_CLEAR : state;
         S_CLEAR:        nxt = (clear_waddr == ADDR_W'(NUM_BINS - 1)) ? S_HIST : S_CLEAR;
         S_ERR:          nxt = S_ERR;
         default:        nxt = valid_done ? state_t'(state + 3'd1) : timeout ? S_ERR : state;
      endcase
   end
   // Outputs are decoded from the next state so every grant change is a single registered edge.
   always_comb begin
      grant_d = {nxt == S_OUT, nxt == S_DIV, nxt == S_CDF, nxt == S_HIST, nxt == S_CLEAR};
      start_d = grant_d[4:1] & {4{nxt != state}};
      addr_d = (nxt == S_CLEAR && state == S_CLEAR) ? clear_waddr + 1'b1 : '0;
      busy_d = |grant_d;
      frame_done_d = nxt == S_DONE && state != S_DONE;
      error_d = nxt == S_ERR;
   end
   assign clear_wdata = '0;
   assign phase = state;
endmodule
